// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared types and address offsets for the register bank
package reg_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_HOLD  = 2'd1,
        ST_WAIT_END = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DEC_NONE = 2'd0,
        DEC_CTRL = 2'd1,
        DEC_STAT = 2'd2,
        DEC_IRQ  = 2'd3
    } dec_e;

    localparam logic [7:0] STAT_OFS = 8'h10;
    localparam logic [7:0] IRQ_OFS  = 8'h20;

    function automatic dec_e dec_classify(input logic hit_ctrl, input logic hit_stat,
                                          input logic hit_irq);
        if (hit_ctrl)      return DEC_CTRL;
        else if (hit_stat) return DEC_STAT;
        else if (hit_irq)  return DEC_IRQ;
        else               return DEC_NONE;
    endfunction

endpackage

// File: rtl/reg_bank_decode.sv
// rtl/reg_bank_decode.sv - combinational address decode into ctrl/stat/irq hits and index
module reg_bank_decode
    import reg_bank_pkg::*;
#(
    parameter int              AW        = 8,
    parameter int              NUM_CTRL  = 4,
    parameter int              NUM_STAT  = 2,
    parameter logic [AW-1:0]   BASE_ADDR = 8'h10
) (
    input  logic [AW-1:0] addr,
    output logic          hit_ctrl,
    output logic          hit_stat,
    output logic          hit_irq,
    output logic [3:0]    index
);

    localparam logic [AW-1:0] STAT_BASE = BASE_ADDR + AW'(STAT_OFS);
    localparam logic [AW-1:0] IRQ_ADDR  = BASE_ADDR + AW'(IRQ_OFS);

    logic [AW-1:0] ofs_ctrl;
    logic [AW-1:0] ofs_stat;

    // Subtraction wraps modulo 2^AW, so addresses below a base land far out of range.
    always_comb begin
        ofs_ctrl = addr - BASE_ADDR;
        ofs_stat = addr - STAT_BASE;
        hit_ctrl = 32'(ofs_ctrl) < 32'(NUM_CTRL);
        hit_stat = !hit_ctrl && (32'(ofs_stat) < 32'(NUM_STAT));
        hit_irq  = !hit_ctrl && !hit_stat && (addr == IRQ_ADDR);
        index    = hit_stat ? ofs_stat[3:0] : ofs_ctrl[3:0];
    end

endmodule

// File: rtl/reg_bank_ctrl.sv
// rtl/reg_bank_ctrl.sv - host-bus register bank with ctrl, status and W1C irq-pending registers
module reg_bank_ctrl
    import reg_bank_pkg::*;
#(
    parameter int            AW        = 8,
    parameter int            DW        = 8,
    parameter int            NUM_CTRL  = 4,
    parameter int            NUM_STAT  = 2,
    parameter logic [AW-1:0] BASE_ADDR = 8'h10,
    parameter logic [DW-1:0] CTRL_RST  = '0
) (
    input  logic                   sys_clk_25m,
    input  logic                   sys_rst,
    input  logic [AW-1:0]          reg_addr,
    input  logic [DW-1:0]          reg_wr_data,
    input  logic                   reg_rw,
    input  logic                   reg_rw_start,
    input  logic                   reg_rw_end,
    output logic [DW-1:0]          reg_rd_data,
    output logic                   reg_out_oe,
    output logic                   reg_ack,
    output logic                   reg_err,
    output logic [NUM_CTRL*DW-1:0] ctrl_regs,
    output logic [NUM_CTRL-1:0]    ctrl_wr_stb,
    input  logic [NUM_STAT*DW-1:0] stat_in,
    input  logic [DW-1:0]          irq_event,
    output logic                   irq
);

    state_e                state_q, state_d;
    logic [DW-1:0]         rd_data_q, rd_data_d;
    logic                  oe_q, oe_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [NUM_CTRL-1:0]   stb_q, stb_d;
    logic [DW-1:0]         pending_q, pending_d;
    logic                  irq_q, irq_d;
    logic [DW-1:0]         w1c_clr;
    logic [NUM_CTRL*DW-1:0] ctrl_flat;

    logic       hit_ctrl, hit_stat, hit_irq;
    logic [3:0] index;
    dec_e       dec;
    logic [DW-1:0] ctrl_rd, stat_rd;

    reg_bank_decode #(
        .AW        (AW),
        .NUM_CTRL  (NUM_CTRL),
        .NUM_STAT  (NUM_STAT),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .addr     (reg_addr),
        .hit_ctrl (hit_ctrl),
        .hit_stat (hit_stat),
        .hit_irq  (hit_irq),
        .index    (index)
    );

    always_comb begin
        dec     = dec_classify(hit_ctrl, hit_stat, hit_irq);
        ctrl_rd = '0;
        for (int i = 0; i < NUM_CTRL; i++)
            if (index == 4'(i)) ctrl_rd = ctrl_flat[i*DW +: DW];
        stat_rd = '0;
        for (int j = 0; j < NUM_STAT; j++)
            if (index == 4'(j)) stat_rd = stat_in[j*DW +: DW];
    end

    // An access is taken only from IDLE, so a held start level executes once.
    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        oe_d      = oe_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        stb_d     = '0;
        w1c_clr   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (reg_rw_start) begin
                    ack_d = 1'b1;
                    err_d = (dec == DEC_NONE);
                    if (reg_rw) begin
                        oe_d    = 1'b1;
                        state_d = ST_RD_HOLD;
                        unique case (dec)
                            DEC_CTRL: rd_data_d = ctrl_rd;
                            DEC_STAT: rd_data_d = stat_rd;
                            DEC_IRQ:  rd_data_d = pending_q;
                            default:  rd_data_d = '0;
                        endcase
                    end else begin
                        state_d = ST_WAIT_END;
                        if (dec == DEC_CTRL) begin
                            for (int i = 0; i < NUM_CTRL; i++)
                                if (index == 4'(i)) stb_d[i] = 1'b1;
                        end
                        if (dec == DEC_IRQ) w1c_clr = reg_wr_data;
                    end
                end
            end
            ST_RD_HOLD, ST_WAIT_END: begin
                if (reg_rw_end) begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // New events override a simultaneous clear of the same bit.
        pending_d = (pending_q & ~w1c_clr) | irq_event;
        irq_d     = |pending_q;
    end

    always_ff @(posedge sys_clk_25m) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            rd_data_q <= '0;
            oe_q      <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            stb_q     <= '0;
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
            oe_q      <= oe_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            stb_q     <= stb_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    for (genvar i = 0; i < NUM_CTRL; i++) begin : g_ctrl
        logic [DW-1:0] ctrl_q, ctrl_d;
        always_comb ctrl_d = stb_d[i] ? reg_wr_data : ctrl_q;
        always_ff @(posedge sys_clk_25m) begin
            if (sys_rst) ctrl_q <= CTRL_RST;
            else         ctrl_q <= ctrl_d;
        end
        assign ctrl_flat[i*DW +: DW] = ctrl_q;
    end

    assign ctrl_regs   = ctrl_flat;
    assign reg_rd_data = rd_data_q;
    assign reg_out_oe  = oe_q;
    assign reg_ack     = ack_q;
    assign reg_err     = err_q;
    assign ctrl_wr_stb = stb_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// tb/tb_reg_bank_ctrl.sv - self-checking bench for reg_bank_ctrl against a behavioural model
module tb_reg_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr, wd;
    logic        rw, start, rw_end;
    logic [7:0]  rd;
    logic        oe, ack, err;
    logic [31:0] ctrl_regs;
    logic [3:0]  stb;
    logic [15:0] stat_in;
    logic [7:0]  ev;
    logic        irq;

    always #20 clk = ~clk;

    reg_bank_ctrl dut (
        .sys_clk_25m  (clk),
        .sys_rst      (rst),
        .reg_addr     (addr),
        .reg_wr_data  (wd),
        .reg_rw       (rw),
        .reg_rw_start (start),
        .reg_rw_end   (rw_end),
        .reg_rd_data  (rd),
        .reg_out_oe   (oe),
        .reg_ack      (ack),
        .reg_err      (err),
        .ctrl_regs    (ctrl_regs),
        .ctrl_wr_stb  (stb),
        .stat_in      (stat_in),
        .irq_event    (ev),
        .irq          (irq)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] ctrl_m [4];
    logic [7:0] pend_m = '0, rd_m = '0;
    logic       oe_m = 0, ack_m = 0, err_m = 0, irq_m = 0, busy = 0;
    logic [3:0] stb_m = '0;
    logic       rand_ev = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge, evaluated from the inputs currently driven.
    task automatic tick();
        logic [7:0] clr, oc, os;
        clr = '0; ack_m = 0; err_m = 0; stb_m = '0;
        if (rst) begin
            for (int i = 0; i < 4; i++) ctrl_m[i] = 8'h00;
            pend_m = '0; rd_m = '0; oe_m = 0; irq_m = 0; busy = 0;
        end else begin
            irq_m = |pend_m;
            oc = addr - 8'h10;
            os = addr - 8'h20;
            if (!busy && start) begin
                busy = 1; ack_m = 1;
                if (rw) begin
                    oe_m = 1;
                    if (oc < 4)             rd_m = ctrl_m[oc[1:0]];
                    else if (os < 2)        rd_m = os[0] ? stat_in[15:8] : stat_in[7:0];
                    else if (addr == 8'h30) rd_m = pend_m;
                    else begin rd_m = '0; err_m = 1; end
                end else begin
                    if (oc < 4) begin ctrl_m[oc[1:0]] = wd; stb_m[oc[1:0]] = 1'b1; end
                    else if (os < 2) begin end
                    else if (addr == 8'h30) clr = wd;
                    else err_m = 1;
                end
            end else if (busy && rw_end) begin
                busy = 0; oe_m = 0;
            end
            pend_m = (pend_m & ~clr) | ev;
        end
        @(posedge clk); #1;
        ev = rand_ev ? (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00) : 8'h00;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ack"}, 32'(ack), 32'(ack_m));
        chk({tag, ".err"}, 32'(err), 32'(err_m));
        chk({tag, ".oe"}, 32'(oe), 32'(oe_m));
        chk({tag, ".rd"}, 32'(rd), 32'(rd_m));
        chk({tag, ".stb"}, 32'(stb), 32'(stb_m));
        chk({tag, ".ctrl"}, ctrl_regs, {ctrl_m[3], ctrl_m[2], ctrl_m[1], ctrl_m[0]});
        chk({tag, ".irq"}, 32'(irq), 32'(irq_m));
    endtask

    task automatic access(input string tag, input logic [7:0] a, input logic [7:0] d,
                          input logic r, input int hold);
        addr = a; wd = d; rw = r; start = 1;
        tick(); check_all({tag, ".exec"});
        for (int k = 0; k < hold; k++) begin
            tick(); check_all({tag, ".hold"});
        end
        start = 0; rw_end = 1;
        tick(); check_all({tag, ".end"});
        rw_end = 0;
    endtask

    initial begin
        rst = 1; addr = '0; wd = '0; rw = 0; start = 0; rw_end = 0; stat_in = '0; ev = '0;
        for (int i = 0; i < 4; i++) ctrl_m[i] = 8'h00;
        tick(); tick();
        check_all("reset");
        rst = 0;
        tick(); check_all("idle");

        access("wr12", 8'h12, 8'h5A, 0, 5);
        chk("reg2_value", 32'(ctrl_regs[23:16]), 32'h5A);
        access("rd12", 8'h12, 8'h00, 1, 2);
        chk("rd12_value", 32'(rd), 32'h5A);
        stat_in = 16'hC3_7E;
        access("rd21", 8'h21, 8'h00, 1, 1);
        chk("stat1_value", 32'(rd), 32'hC3);
        access("rd14", 8'h14, 8'h00, 1, 0);
        access("wr30x", 8'h40, 8'hFF, 0, 0);
        access("wr20", 8'h20, 8'hAA, 0, 1);
        access("wr0f", 8'h0F, 8'h11, 0, 0);

        rw_end = 1; tick(); check_all("end_in_idle"); rw_end = 0;

        ev = 8'h05; tick(); check_all("ev05");
        tick(); check_all("irq_up");
        chk("irq_set", 32'(irq), 32'h1);
        ev = 8'h04;
        access("w1c_race", 8'h30, 8'h04, 0, 0);
        access("rd30", 8'h30, 8'h00, 1, 0);
        chk("pend_after_race", 32'(rd), 32'h05);
        access("w1c_all", 8'h30, 8'h05, 0, 0);
        tick(); check_all("irq_down");
        chk("irq_clear", 32'(irq), 32'h0);

        addr = 8'h11; rw = 1; start = 1;
        tick(); check_all("rd_before_rst");
        start = 0; rst = 1;
        tick(); check_all("rst_in_hold");
        addr = 8'h11; wd = 8'hFF; rw = 0; start = 1;
        tick(); check_all("wr_in_rst");
        rst = 0; start = 0;
        tick(); check_all("after_rst");
        chk("no_write_in_rst", 32'(ctrl_regs[15:8]), 32'h00);

        rand_ev = 1;
        for (int n = 0; n < 60; n++) begin
            logic [7:0] a;
            case ($urandom_range(0, 7))
                0, 1, 2, 3: a = 8'h10 + 8'($urandom_range(0, 3));
                4:          a = 8'h20;
                5:          a = 8'h21;
                6:          a = 8'h30;
                default:    a = 8'($urandom);
            endcase
            stat_in = 16'($urandom);
            access("rand", a, 8'($urandom), 1'($urandom), $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin tick(); check_all("rand_idle"); end
        end
        rand_ev = 0;
        tick(); check_all("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
